// File: rtl/skeleton_echo_fifo_if.sv
// Handshake bundle for skeleton_echo_fifo: the test driver uses the master side, the echo buffer the slave side.
interface skeleton_echo_fifo_if #(
  parameter int BITWIDTH_DATA = 16,
  parameter int BITWIDTH_HEAD = 26,
  parameter int DEPTH_LOG2    = 4
);
  logic                     EN;
  logic                     WR_EN;
  logic [BITWIDTH_DATA-1:0] DATA_IN;
  logic                     TRGG_START_CALC;
  logic                     RD_ACK;
  logic [BITWIDTH_DATA-1:0] DATA_OUT;
  logic [BITWIDTH_HEAD-1:0] DATA_HEAD;
  logic                     DATA_VALID;
  logic [DEPTH_LOG2:0]      FIFO_COUNT;
  logic                     FIFO_FULL;
  logic                     FIFO_EMPTY;
  logic                     BUSY;
  logic                     OVERFLOW;

  modport master (
    output EN, WR_EN, DATA_IN, TRGG_START_CALC, RD_ACK,
    input  DATA_OUT, DATA_HEAD, DATA_VALID, FIFO_COUNT, FIFO_FULL, FIFO_EMPTY, BUSY, OVERFLOW
  );

  modport slave (
    input  EN, WR_EN, DATA_IN, TRGG_START_CALC, RD_ACK,
    output DATA_OUT, DATA_HEAD, DATA_VALID, FIFO_COUNT, FIFO_FULL, FIFO_EMPTY, BUSY, OVERFLOW
  );
endinterface

// File: rtl/skeleton_echo_fifo.sv
// Buffered echo skeleton: captures a burst, replays it on trigger with valid/ack flow control.
// Define SKELETON_ECHO_LIFO_EN for last-in-first-out replay; FIFO order otherwise.
module skeleton_echo_fifo #(
  parameter int BITWIDTH_DATA = 16,
  parameter int BITWIDTH_HEAD = 26,
  parameter int DEPTH_LOG2    = 4
) (
  input logic                CLK_SYS,
  input logic                RSTN,
  skeleton_echo_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]      CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
`ifdef SKELETON_ECHO_LIFO_EN
  localparam logic [3:0] MODE = 4'd3;
`else
  localparam logic [3:0] MODE = 4'd2;
`endif
  localparam logic [5:0] HEAD_DEPTH = 6'(DEPTH_LOG2);
  localparam logic [4:0] HEAD_WIDTH = 5'(BITWIDTH_DATA);
  localparam logic [BITWIDTH_HEAD-1:0] HEAD_C =
    BITWIDTH_HEAD'({MODE, HEAD_DEPTH, 6'd1, HEAD_WIDTH, HEAD_WIDTH});

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                   state_r;
  logic [BITWIDTH_DATA-1:0] mem_r [DEPTH];
  logic [BITWIDTH_DATA-1:0] data_out_r;
  logic                     valid_r;
  logic                     busy_r;
  logic                     ovf_r;
  logic                     full_r;
  logic                     empty_r;
  logic [CNT_W-1:0]         count_r;
  logic [CNT_W-1:0]         count_nxt_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     load_s;
  logic                     ovf_s;
  logic [DEPTH_LOG2-1:0]    wr_idx_s;
  logic [DEPTH_LOG2-1:0]    rd_idx_s;
`ifdef SKELETON_ECHO_LIFO_EN
  logic [DEPTH_LOG2-1:0]    sp_r;
`else
  logic [DEPTH_LOG2-1:0]    wr_ptr_r;
  logic [DEPTH_LOG2-1:0]    rd_ptr_r;
`endif

  // Decode this cycle's push, pop, output-register load and rejected write.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    load_s = 1'b0;
    ovf_s  = 1'b0;
    if (bus.EN) begin
      case (state_r)
        S_IDLE: begin
          push_s = bus.WR_EN;
        end
        S_FILL: begin
          push_s = bus.WR_EN && !full_r;
          ovf_s  = bus.WR_EN && full_r;
        end
        S_DRAIN: begin
          ovf_s  = bus.WR_EN;
          pop_s  = valid_r && bus.RD_ACK;
          // first load right after the trigger, then refill on every pop but the last
          load_s = !valid_r || (pop_s && (count_r != CNT_ONE));
        end
        default: begin
          push_s = 1'b0;
        end
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  // Word count includes the word parked in the output register.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (pop_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Buffer addressing: the stack variant reuses one pointer for both ends.
  always_comb begin
`ifdef SKELETON_ECHO_LIFO_EN
    wr_idx_s = sp_r;
    rd_idx_s = sp_r - PTR_ONE;
`else
    wr_idx_s = wr_ptr_r;
    rd_idx_s = rd_ptr_r;
`endif
  end

  // Storage array; contents are don't-care once the count says empty.
  always_ff @(posedge CLK_SYS) begin
    if (push_s) begin
      mem_r[wr_idx_s] <= bus.DATA_IN;
    end
  end

  // Control FSM, pointers, count and all registered status outputs.
  always_ff @(posedge CLK_SYS or negedge RSTN) begin
    if (!RSTN) begin
      state_r    <= S_IDLE;
      data_out_r <= {BITWIDTH_DATA{1'b0}};
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      ovf_r      <= 1'b0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      count_r    <= CNT_ZERO;
`ifdef SKELETON_ECHO_LIFO_EN
      sp_r       <= PTR_ZERO;
`else
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
`endif
    end else if (!bus.EN) begin
      state_r    <= S_IDLE;
      data_out_r <= {BITWIDTH_DATA{1'b0}};
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      ovf_r      <= 1'b0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      count_r    <= CNT_ZERO;
`ifdef SKELETON_ECHO_LIFO_EN
      sp_r       <= PTR_ZERO;
`else
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
`endif
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == CNT_ZERO);
      if (ovf_s) begin
        ovf_r <= 1'b1;
      end
      if (load_s) begin
        data_out_r <= mem_r[rd_idx_s];
      end
`ifdef SKELETON_ECHO_LIFO_EN
      if (push_s) begin
        sp_r <= sp_r + PTR_ONE;
      end else if (load_s) begin
        sp_r <= sp_r - PTR_ONE;
      end
`else
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
`endif
      case (state_r)
        S_IDLE: begin
          if (push_s) begin
            state_r <= S_FILL;
          end
        end
        S_FILL: begin
          if (bus.TRGG_START_CALC) begin
            state_r <= S_DRAIN;
            busy_r  <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!valid_r) begin
            valid_r <= 1'b1;
          end else if (pop_s && (count_r == CNT_ONE)) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DATA_OUT   = data_out_r;
  assign bus.DATA_HEAD  = HEAD_C;
  assign bus.DATA_VALID = valid_r;
  assign bus.FIFO_COUNT = count_r;
  assign bus.FIFO_FULL  = full_r;
  assign bus.FIFO_EMPTY = empty_r;
  assign bus.BUSY       = busy_r;
  assign bus.OVERFLOW   = ovf_r;
endmodule

// File: tb/tb_skeleton_echo_fifo.sv
// Self-checking bench for skeleton_echo_fifo: vector table, directed corner cases, random vs queue model.
module tb_skeleton_echo_fifo;
  localparam int BW = 16;
  localparam int BH = 26;
  localparam int DL = 4;
  localparam int DEPTH = 16;
`ifdef SKELETON_ECHO_LIFO_EN
  localparam logic [25:0] EXP_HEAD = {4'd3, 6'd4, 6'd1, 5'd16, 5'd16};
  localparam bit LIFO = 1'b1;
`else
  localparam logic [25:0] EXP_HEAD = {4'd2, 6'd4, 6'd1, 5'd16, 5'd16};
  localparam bit LIFO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  skeleton_echo_fifo_if #(.BITWIDTH_DATA(BW), .BITWIDTH_HEAD(BH), .DEPTH_LOG2(DL)) bus ();

  skeleton_echo_fifo #(.BITWIDTH_DATA(BW), .BITWIDTH_HEAD(BH), .DEPTH_LOG2(DL)) dut (
    .CLK_SYS(clk),
    .RSTN   (rstn),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: queue holds stored words in replay order, head = word on DATA_OUT
  logic [15:0] m_q[$];
  int          m_mode;   // 0 idle, 1 filling, 2 replaying
  bit          m_valid;
  bit          m_ovf;

  typedef struct {
    logic        wr;
    logic [15:0] din;
    logic        trig;
    logic        ack;
    logic        e_valid;
    logic [15:0] e_out;
    logic [4:0]  e_count;
    logic        e_busy;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode  = 0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_push(input logic [15:0] d);
    if (LIFO) m_q.push_front(d);
    else      m_q.push_back(d);
  endtask

  task automatic model_step();
    if (!bus.EN) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (bus.WR_EN) begin
        model_push(bus.DATA_IN);
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (bus.WR_EN) begin
        if (m_q.size() < DEPTH) model_push(bus.DATA_IN);
        else m_ovf = 1'b1;
      end
      if (bus.TRGG_START_CALC) m_mode = 2;
    end else begin
      if (bus.WR_EN) m_ovf = 1'b1;
      if (!m_valid) begin
        m_valid = 1'b1;
      end else if (bus.RD_ACK) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_valid = 1'b0;
          m_mode  = 0;
        end
      end
    end
  endtask

  task automatic step(input logic en, input logic wr, input logic [15:0] din,
                      input logic trig, input logic ack);
    bus.EN = en;
    bus.WR_EN = wr;
    bus.DATA_IN = din;
    bus.TRGG_START_CALC = trig;
    bus.RD_ACK = ack;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cmp_model();
    chk("m_valid", 32'(bus.DATA_VALID), 32'(m_valid));
    chk("m_busy", 32'(bus.BUSY), 32'(m_mode == 2));
    chk("m_count", 32'(bus.FIFO_COUNT), 32'(m_q.size()));
    chk("m_full", 32'(bus.FIFO_FULL), 32'(m_q.size() == DEPTH));
    chk("m_empty", 32'(bus.FIFO_EMPTY), 32'(m_q.size() == 0));
    chk("m_ovf", 32'(bus.OVERFLOW), 32'(m_ovf));
    if (m_valid) chk("m_data", 32'(bus.DATA_OUT), 32'(m_q[0]));
  endtask

  task automatic mstep(input logic en, input logic wr, input logic [15:0] din,
                       input logic trig, input logic ack);
    step(en, wr, din, trig, ack);
    cmp_model();
  endtask

  // acknowledge until replay ends, collecting each delivered word
  task automatic drain_collect(output logic [15:0] got[$]);
    got.delete();
    for (int c = 0; c < 40; c++) begin
      if (bus.DATA_VALID) got.push_back(bus.DATA_OUT);
      mstep(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      if (!bus.BUSY) break;
    end
    chk("drain_done", 32'(bus.BUSY), 32'd0);
  endtask

  initial begin
    logic [15:0] got[$];
    logic [15:0] w_a;
    logic [15:0] w_c;
    logic [15:0] want;
    int vcnt;

    bus.EN = 1'b1;
    bus.WR_EN = 1'b0;
    bus.DATA_IN = 16'h0000;
    bus.TRGG_START_CALC = 1'b0;
    bus.RD_ACK = 1'b0;
    model_reset();

    #12;
    chk("rst_valid", 32'(bus.DATA_VALID), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_count", 32'(bus.FIFO_COUNT), 32'd0);
    chk("rst_full", 32'(bus.FIFO_FULL), 32'd0);
    chk("rst_empty", 32'(bus.FIFO_EMPTY), 32'd1);
    chk("rst_ovf", 32'(bus.OVERFLOW), 32'd0);
    chk("rst_data", 32'(bus.DATA_OUT), 32'd0);
    chk("header", 32'(bus.DATA_HEAD), 32'(EXP_HEAD));
    #5 rstn = 1'b1;

    // order table: three writes, trigger, RD_ACK held high
    w_a = LIFO ? 16'h0033 : 16'h0011;
    w_c = LIFO ? 16'h0011 : 16'h0033;
    tbl[0] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0};
    tbl[1] = '{1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd2, 1'b0};
    tbl[2] = '{1'b1, 16'h0033, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd3, 1'b0};
    tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 5'd3, 1'b1};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, w_a,      5'd3, 1'b1};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0022, 5'd2, 1'b1};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, w_c,      5'd1, 1'b1};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b0};
    vcnt = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, tbl[i].wr, tbl[i].din, tbl[i].trig, tbl[i].ack);
      if (bus.DATA_VALID) vcnt++;
      chk("tbl_valid", 32'(bus.DATA_VALID), 32'(tbl[i].e_valid));
      chk("tbl_count", 32'(bus.FIFO_COUNT), 32'(tbl[i].e_count));
      chk("tbl_busy", 32'(bus.BUSY), 32'(tbl[i].e_busy));
      if (tbl[i].e_valid) chk("tbl_data", 32'(bus.DATA_OUT), 32'(tbl[i].e_out));
    end
    chk("tbl_valid_cycles", 32'(vcnt), 32'd3);

    // full and overflow: 17 writes into 16 slots
    mstep(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) mstep(1'b1, 1'b1, 16'(i), 1'b0, 1'b0);
    chk("full_flag", 32'(bus.FIFO_FULL), 32'd1);
    chk("full_count", 32'(bus.FIFO_COUNT), 32'd16);
    chk("full_ovf", 32'(bus.OVERFLOW), 32'd1);
    mstep(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain_collect(got);
    chk("full_n", 32'(got.size()), 32'd16);
    for (int i = 0; i < got.size(); i++) begin
      want = LIFO ? 16'(15 - i) : 16'(i);
      chk("full_word", 32'(got[i]), 32'(want));
    end

    // backpressure: RD_ACK low for five cycles after trigger
    mstep(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    mstep(1'b1, 1'b1, 16'h00A1, 1'b0, 1'b0);
    mstep(1'b1, 1'b1, 16'h00B2, 1'b0, 1'b0);
    mstep(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) mstep(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("bp_hold", 32'(bus.DATA_OUT), LIFO ? 32'h00B2 : 32'h00A1);
    chk("bp_valid", 32'(bus.DATA_VALID), 32'd1);
    mstep(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("bp_second", 32'(bus.DATA_OUT), LIFO ? 32'h00A1 : 32'h00B2);
    mstep(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("bp_idle", 32'({bus.BUSY, bus.DATA_VALID}), 32'd0);

    // pointer wrap: three fill-10 / drain-10 rounds
    mstep(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) mstep(1'b1, 1'b1, 16'(r * 256 + i + 1), 1'b0, 1'b0);
      mstep(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      drain_collect(got);
      chk("wrap_n", 32'(got.size()), 32'd10);
      for (int i = 0; i < got.size(); i++) begin
        want = LIFO ? 16'(r * 256 + 10 - i) : 16'(r * 256 + i + 1);
        chk("wrap_word", 32'(got[i]), 32'(want));
      end
      chk("wrap_empty", 32'(bus.FIFO_EMPTY), 32'd1);
    end

    // asynchronous reset mid-replay, no clock edge in between
    for (int i = 0; i < 4; i++) mstep(1'b1, 1'b1, 16'(16'h0C00 + i), 1'b0, 1'b0);
    mstep(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    mstep(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    mstep(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    bus.RD_ACK = 1'b0;
    bus.WR_EN = 1'b0;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", 32'(bus.DATA_VALID), 32'd0);
    chk("arst_count", 32'(bus.FIFO_COUNT), 32'd0);
    chk("arst_busy", 32'(bus.BUSY), 32'd0);
    chk("arst_ovf", 32'(bus.OVERFLOW), 32'd0);
    chk("arst_empty", 32'(bus.FIFO_EMPTY), 32'd1);
    chk("arst_data", 32'(bus.DATA_OUT), 32'd0);
    #2 rstn = 1'b1;

    // EN low mid-replay clears on the next edge
    for (int i = 0; i < 4; i++) mstep(1'b1, 1'b1, 16'(16'h0D00 + i), 1'b0, 1'b0);
    mstep(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    mstep(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    mstep(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("en_valid", 32'(bus.DATA_VALID), 32'd0);
    chk("en_count", 32'(bus.FIFO_COUNT), 32'd0);
    chk("en_data", 32'(bus.DATA_OUT), 32'd0);

    // trigger with an empty buffer is ignored
    mstep(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    mstep(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    chk("trig_empty_busy", 32'(bus.BUSY), 32'd0);
    chk("trig_empty_valid", 32'(bus.DATA_VALID), 32'd0);

    // write during replay is rejected and flagged
    mstep(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
    mstep(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0);
    mstep(1'b1, 1'b1, 16'h3333, 1'b1, 1'b0);
    mstep(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("drain_wr_ovf", 32'(bus.OVERFLOW), 32'd1);
    drain_collect(got);
    chk("drain_wr_n", 32'(got.size()), 32'd3);
    for (int i = 0; i < got.size(); i++) begin
      want = LIFO ? 16'(16'h3333 - 16'(i) * 16'h1111) : 16'(16'h1111 + 16'(i) * 16'h1111);
      chk("drain_wr_word", 32'(got[i]), 32'(want));
    end

    // random traffic against the queue model
    mstep(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 800; i++) begin
      mstep(1'($urandom_range(0, 59) != 0),
            1'($urandom_range(0, 2) != 0),
            16'($urandom),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/skeleton_echo_fifo.md
# skeleton_echo_fifo

Buffered echo skeleton for on-device loopback tests. Captures a burst of up to 2^DEPTH_LOG2 input words, then on a start trigger replays them to the host readout path with a valid/acknowledge handshake. It also exposes a metadata header describing its configuration. It occupies the same slot in the FPGA test design as the plain combinational echo skeleton, but adds buffering, flow control and overflow reporting.

## Interface
- BITWIDTH_DATA, 16: data word width; legal range 1..31, because it is encoded in 5 header bits.
- BITWIDTH_HEAD, 26: header width; fixed at 26.
- DEPTH_LOG2, 4: log2 of the buffer depth, giving DEPTH = 16; legal range 1..8.

- CLK_SYS  in  1  system clock; all logic is on the rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- EN  in  1  synchronous enable; low behaves as a synchronous clear.
- WR_EN  in  1  pushes DATA_IN into the buffer in this cycle.
- DATA_IN  in  BITWIDTH_DATA  word to capture.
- TRGG_START_CALC  in  1  starts replay; sampled as a level.
- RD_ACK  in  1  consumer accepts DATA_OUT in this cycle.
- DATA_OUT  out  BITWIDTH_DATA  replayed word; registered.
- DATA_HEAD  out  BITWIDTH_HEAD  constant metadata.
- DATA_VALID  out  1  DATA_OUT holds a word not yet accepted.
- FIFO_COUNT  out  DEPTH_LOG2+1  words stored, including the word in the output register.
- FIFO_FULL  out  1  FIFO_COUNT == DEPTH.
- FIFO_EMPTY  out  1  FIFO_COUNT == 0.
- BUSY  out  1  replay in progress.
- OVERFLOW  out  1  sticky flag for a rejected write.

## Operation
- DATA_HEAD = {MODE[3:0], DEPTH_LOG2[5:0], 6'd1, BITWIDTH_DATA[4:0], BITWIDTH_DATA[4:0]}.
  - MODE = 4'd2 in FIFO order.
  - MODE = 4'd3 in LIFO order.
- The FSM has three states: S_IDLE, S_FILL and S_DRAIN.
- S_IDLE
  - WR_EN pushes the word and moves to S_FILL.
  - TRGG_START_CALC is ignored, because the buffer is empty.
- S_FILL
  - WR_EN pushes a word while not full.
  - WR_EN while full drops the word, sets OVERFLOW and leaves FIFO_COUNT unchanged.
  - TRGG_START_CALC moves to S_DRAIN. A WR_EN in the same cycle is still accepted if the buffer is not full; the trigger has priority for the state change.
- S_DRAIN
  - BUSY = 1.
  - The first word is loaded into DATA_OUT and DATA_VALID is set.
  - Each cycle with DATA_VALID && RD_ACK pops one word. The next word appears after that edge with no bubble.
  - After the last word is popped, DATA_VALID = 0 and the FSM returns to S_IDLE.
  - WR_EN in this state is rejected and sets OVERFLOW.
  - TRGG_START_CALC in this state is ignored.
- RD_ACK while DATA_VALID = 0 has no effect.
- Read and write pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH.
- FIFO_COUNT is one bit wider than the pointers, so that full and empty can be distinguished.
- OVERFLOW clears only on RSTN low or EN low.
- Reset values (RSTN low, asynchronous): state S_IDLE, pointers 0, FIFO_COUNT 0, DATA_OUT 0, DATA_VALID 0, BUSY 0, OVERFLOW 0, FIFO_FULL 0, FIFO_EMPTY 1.
- EN low: all registers return to their reset values at the next edge. Buffered data is discarded.
- Reset or EN low mid-replay aborts the replay immediately. Remaining words are lost.

## Timing
- Latency from a trigger sampled at edge N:
  - BUSY = 1 after edge N.
  - DATA_VALID = 1 and DATA_OUT = first word after edge N+1.
- Throughput is one word per cycle while RD_ACK is held high.
- The final RD_ACK at edge M gives DATA_VALID = 0, BUSY = 0 and state S_IDLE after edge M.
- DATA_OUT holds stable while DATA_VALID && !RD_ACK.
- FIFO_COUNT, FIFO_FULL and FIFO_EMPTY update at the edge that performs the push or pop.
- DATA_HEAD is constant and carries no timing.

## Configuration
- SKELETON_ECHO_LIFO_EN defined: replay is in reverse order, last written word first. Writes and pops share one stack pointer. The header MODE field is 4'd3.
- SKELETON_ECHO_LIFO_EN undefined: replay is in FIFO order, first written word first. The header MODE field is 4'd2.
- The interface and timing are identical in both modes.

## Test plan
- Order and header: write 0x0011, 0x0022, 0x0033, trigger, hold RD_ACK high.
  - FIFO mode: DATA_OUT = 0x0011, 0x0022, 0x0033 on consecutive cycles; DATA_VALID high for exactly 3 cycles; DATA_HEAD = {4'd2, 6'd4, 6'd1, 5'd16, 5'd16}.
  - LIFO mode: DATA_OUT = 0x0033, 0x0022, 0x0011; DATA_HEAD MODE field = 4'd3.
- Full and overflow: write 17 words (0..16) with DEPTH = 16.
  - FIFO_FULL = 1 and FIFO_COUNT = 16; OVERFLOW = 1.
  - Replay yields words 0..15 in FIFO mode; word 16 is never output.
- Backpressure: load 2 words, trigger, hold RD_ACK low for 5 cycles.
  - DATA_OUT stays at the first word and DATA_VALID stays 1.
  - Then acknowledge twice: both words are delivered and the FSM is back in S_IDLE.
- Wrap-around: run fill 10 / drain 10 three times in sequence.
  - Every word is replayed correctly in every round.
  - FIFO_EMPTY = 1 after each drain.
- Abort: assert RSTN low asynchronously mid-drain, with no clock edge.
  - Outputs immediately show the reset values; DATA_VALID = 0 and FIFO_COUNT = 0.
  - Repeat the same case with EN low: the same values appear after one edge.
- Illegal events:
  - Trigger with an empty buffer: no DATA_VALID, BUSY stays 0.
  - WR_EN during S_DRAIN: OVERFLOW = 1, replay contents unchanged.
